wb_master_arbiter: RTL and testbench

- Shares the CPU's single Wishbone classic master port between two internal requesters: instruction fetch (port I) and load/store (port D).
- Each requester uses a simple hold-until-done interface; the block sequences the Wishbone cycle and applies round-robin grant.
- Handles bus error, retry with backoff and a retry limit, and a no-response timeout.
- Sits between the single-stage core datapath and the CPU top-level bus pins.

---
 rtl/wb_master_arbiter_pkg.sv | 19 +
 rtl/wb_master_arbiter_rr_arb2.sv | 24 ++
 rtl/wb_master_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-requester Wishbone master arbiter:
// FSM encodings, requester IDs and default retry/timeout settings.
package wb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int DEF_MAX_RETRY  = 3;
  localparam int DEF_RETRY_WAIT = 2;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/wb_master_arbiter_rr_arb2.sv
// Combinational 2-way round-robin arbiter: on contention the port that
// did not win last time is granted.
module rr_arb2
  import wb_master_arbiter_pkg::*;
(
  input  logic fetch_req,
  input  logic data_req,
  input  logic last_grant,
  output logic any_req,
  output logic grant
);

  always_comb begin
    any_req = fetch_req | data_req;
    if (fetch_req && data_req) begin
      grant = ~last_grant;
    end else if (data_req) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Shares one Wishbone classic master port between instruction fetch (I)
// and load/store (D), with retry/backoff, retry limit and timeout handling.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int MAX_RETRY  = DEF_MAX_RETRY,
  parameter int RETRY_WAIT = DEF_RETRY_WAIT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_adr_i,
  output logic [DATA_WIDTH-1:0] i_rdat_o,
  output logic                  i_done_o,
  output logic                  i_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_adr_i,
  input  logic [DATA_WIDTH-1:0] d_wdat_i,
  input  logic [SEL_WIDTH-1:0]  d_sel_i,
  output logic [DATA_WIDTH-1:0] d_rdat_o,
  output logic                  d_done_o,
  output logic                  d_err_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  lock_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i,
  output logic                  tgc_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int WW = $clog2(RETRY_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RETRY_WAIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;
  logic [RW-1:0]         retry_cnt_reg, retry_cnt_next;
  logic [WW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic [TW-1:0]         tmo_cnt_reg, tmo_cnt_next;
  logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;
  logic                  we_reg, we_next;
  logic [SEL_WIDTH-1:0]  sel_reg, sel_next;
  logic                  cyc_reg, cyc_next;
  logic                  tgc_reg, tgc_next;
  logic [DATA_WIDTH-1:0] i_rdat_reg, i_rdat_next, d_rdat_reg, d_rdat_next;
  logic                  i_done_reg, i_done_next, d_done_reg, d_done_next;
  logic                  i_err_reg, i_err_next, d_err_reg, d_err_next;
  logic                  resp_fire, resp_err;
  logic                  any_req, grant;

  rr_arb2 u_arb (
    .fetch_req  (i_req_i),
    .data_req   (d_req_i),
    .last_grant (last_grant_reg),
    .any_req    (any_req),
    .grant      (grant)
  );

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    retry_cnt_next  = retry_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    we_next         = we_reg;
    sel_next        = sel_reg;
    cyc_next        = cyc_reg;
    tgc_next        = tgc_reg;
    i_rdat_next     = i_rdat_reg;
    d_rdat_next     = d_rdat_reg;
    i_done_next     = 1'b0;
    d_done_next     = 1'b0;
    i_err_next      = 1'b0;
    d_err_next      = 1'b0;
    resp_fire       = 1'b0;
    resp_err        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          tgc_next     = grant;
          cyc_next     = 1'b1;
          tmo_cnt_next = '0;
          state_next   = ST_BUS;
          if (grant == REQ_D) begin
            adr_next = d_adr_i;
            dat_next = d_wdat_i;
            we_next  = d_we_i;
            sel_next = d_sel_i;
          end else begin
            adr_next = i_adr_i;
            we_next  = 1'b0;
            sel_next = '1;
          end
        end
      end
      ST_BUS: begin
        // Response priority: ack over err over rty.
        if (ack_i) begin
          resp_fire = 1'b1;
          if (tgc_reg == REQ_D) d_rdat_next = dat_i;
          else                  i_rdat_next = dat_i;
        end else if (err_i) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (rty_i) begin
          if (retry_cnt_reg == RETRY_MAX) begin
            resp_fire = 1'b1;
            resp_err  = 1'b1;
          end else begin
            retry_cnt_next = retry_cnt_reg + RW'(1);
            wait_cnt_next  = '0;
            cyc_next       = 1'b0;
            state_next     = ST_BACKOFF;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      ST_BACKOFF: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          cyc_next     = 1'b1;
          tmo_cnt_next = '0;
          state_next   = ST_BUS;
        end else begin
          wait_cnt_next = wait_cnt_reg + WW'(1);
        end
      end
      ST_RESP: begin
        last_grant_next = tgc_reg;
        retry_cnt_next  = '0;
        tmo_cnt_next    = '0;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (resp_fire) begin
      cyc_next   = 1'b0;
      state_next = ST_RESP;
      if (tgc_reg == REQ_D) begin
        d_done_next = 1'b1;
        d_err_next  = resp_err;
      end else begin
        i_done_next = 1'b1;
        i_err_next  = resp_err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= REQ_D;
      retry_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      we_reg         <= 1'b0;
      sel_reg        <= '0;
      cyc_reg        <= 1'b0;
      tgc_reg        <= 1'b0;
      i_rdat_reg     <= '0;
      d_rdat_reg     <= '0;
      i_done_reg     <= 1'b0;
      d_done_reg     <= 1'b0;
      i_err_reg      <= 1'b0;
      d_err_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      retry_cnt_reg  <= retry_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      we_reg         <= we_next;
      sel_reg        <= sel_next;
      cyc_reg        <= cyc_next;
      tgc_reg        <= tgc_next;
      i_rdat_reg     <= i_rdat_next;
      d_rdat_reg     <= d_rdat_next;
      i_done_reg     <= i_done_next;
      d_done_reg     <= d_done_next;
      i_err_reg      <= i_err_next;
      d_err_reg      <= d_err_next;
    end
  end

  assign adr_o    = adr_reg;
  assign dat_o    = dat_reg;
  assign we_o     = we_reg;
  assign sel_o    = sel_reg;
  assign cyc_o    = cyc_reg;
  assign stb_o    = cyc_reg;
  assign lock_o   = 1'b0;
  assign tgc_o    = tgc_reg;
  assign i_rdat_o = i_rdat_reg;
  assign i_done_o = i_done_reg;
  assign i_err_o  = i_err_reg;
  assign d_rdat_o = d_rdat_reg;
  assign d_done_o = d_done_reg;
  assign d_err_o  = d_err_reg;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter; inputs driven and
// outputs sampled on the falling clock edge.
module tb_wb_master_arbiter;

  localparam int MAX_RETRY  = 3;
  localparam int RETRY_WAIT = 2;
  localparam int TIMEOUT    = 255;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req_i, d_req_i, d_we_i;
  logic [31:0] i_adr_i, d_adr_i, d_wdat_i, dat_i;
  logic [3:0]  d_sel_i;
  logic [31:0] i_rdat_o, d_rdat_o, adr_o, dat_o;
  logic        i_done_o, i_err_o, d_done_o, d_err_o;
  logic        we_o, cyc_o, stb_o, lock_o, tgc_o;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_master_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_rdat_o(i_rdat_o),
    .i_done_o(i_done_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_wdat_i(d_wdat_i),
    .d_sel_i(d_sel_i), .d_rdat_o(d_rdat_o), .d_done_o(d_done_o), .d_err_o(d_err_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .lock_o(lock_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .tgc_o(tgc_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    while (cyc_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_cyc_up"}, cyc_o, 1'b1);
  endtask

  task automatic check_done(input string tag, input logic port, input logic exp_err,
                            input logic [31:0] exp_rdat, input bit chk_rdat);
    if (port == 1'b0) begin
      check({tag, "_idone"}, i_done_o, 1'b1);
      check({tag, "_ierr"}, i_err_o, exp_err);
      check({tag, "_dnone"}, d_done_o, 1'b0);
      if (chk_rdat) check({tag, "_irdat"}, i_rdat_o, exp_rdat);
    end else begin
      check({tag, "_ddone"}, d_done_o, 1'b1);
      check({tag, "_derr"}, d_err_o, exp_err);
      check({tag, "_inone"}, i_done_o, 1'b0);
      if (chk_rdat) check({tag, "_drdat"}, d_rdat_o, exp_rdat);
    end
    check({tag, "_cyc_down"}, cyc_o, 1'b0);
  endtask

  // Serves one granted cycle: n_rty retries, then the given final response.
  task automatic run_xact(input string tag, input logic port, input int n_rty,
                          input logic f_ack, input logic f_err,
                          input logic [31:0] rdata, input logic exp_err);
    int gap;
    wait_cyc(tag);
    check({tag, "_tgc"}, tgc_o, port);
    for (int r = 0; r < n_rty; r++) begin
      rty_i = 1'b1;
      step();
      rty_i = 1'b0;
      if (r == MAX_RETRY) begin
        check_done(tag, port, 1'b1, 32'h0, 1'b0);
        $display("xact %s port=%0d retries=%0d -> retry limit error", tag, port, n_rty);
        return;
      end
      gap = 0;
      while (cyc_o !== 1'b1 && gap < 20) begin
        gap++;
        step();
      end
      check({tag, "_gap"}, gap, RETRY_WAIT);
    end
    ack_i = f_ack;
    err_i = f_err;
    dat_i = rdata;
    step();
    ack_i = 1'b0;
    err_i = 1'b0;
    check_done(tag, port, exp_err, rdata, f_ack);
    $display("xact %s port=%0d retries=%0d ack=%0d err=%0d adr=%08h", tag, port, n_rty,
             f_ack, f_err, adr_o);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; i_req_i = 0; d_req_i = 0; d_we_i = 0;
    i_adr_i = '0; d_adr_i = '0; d_wdat_i = '0; d_sel_i = '0; dat_i = '0;
    ack_i = 0; err_i = 0; rty_i = 0;
    step(); step();
    check("rst_cyc", cyc_o, 1'b0);
    check("rst_stb", stb_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_tgc", tgc_o, 1'b0);
    check("rst_done", {i_done_o, d_done_o, i_err_o, d_err_o}, 4'h0);
    check("rst_lock", lock_o, 1'b0);
    rst_i = 1'b0;

    // Single fetch, acked in first BUS cycle
    i_adr_i = 32'h100; i_req_i = 1'b1;
    step();
    check("t1_stb", stb_o, 1'b1);
    check("t1_adr", adr_o, 32'h100);
    check("t1_we", we_o, 1'b0);
    check("t1_sel", sel_o, 4'hF);
    run_xact("t1", 1'b0, 0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    i_req_i = 1'b0;
    step();
    check("t1_idle_cyc", cyc_o, 1'b0);
    check("t1_done_gone", i_done_o, 1'b0);
    check("t1_rdat_hold", i_rdat_o, 32'hDEADBEEF);

    // Contention: alternating grants I, D, I, D
    do_reset();
    i_adr_i = 32'h104; d_adr_i = 32'h200; d_wdat_i = 32'h12345678;
    d_sel_i = 4'hF; d_we_i = 1'b1;
    i_req_i = 1'b1; d_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cyc("t2_pre");
      if (k % 2 == 1) begin
        check("t2_d_we", we_o, 1'b1);
        check("t2_d_adr", adr_o, 32'h200);
        check("t2_d_dat", dat_o, 32'h12345678);
        check("t2_d_sel", sel_o, 4'hF);
      end else begin
        check("t2_i_we", we_o, 1'b0);
        check("t2_i_adr", adr_o, 32'h104);
      end
      run_xact("t2", logic'(k % 2), 0, 1'b1, 1'b0, 32'hA0000000 + k, 1'b0);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    step();

    // Data read with two retries then ack
    d_we_i = 1'b0; d_adr_i = 32'h300; d_req_i = 1'b1;
    run_xact("t3", 1'b1, 2, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
    d_req_i = 1'b0;
    step();
    check("t3_err_idle", d_err_o, 1'b0);
    check("t3_rdat_hold", d_rdat_o, 32'hCAFEF00D);

    // Retry limit exceeded
    d_req_i = 1'b1;
    run_xact("t4", 1'b1, 4, 1'b1, 1'b0, 32'h0, 1'b1);
    d_req_i = 1'b0;
    step();
    check("t4_err_idle", d_err_o, 1'b0);

    // Timeout with no slave response
    i_adr_i = 32'h400; i_req_i = 1'b1;
    wait_cyc("t5");
    n = 0;
    while (cyc_o === 1'b1 && n < 400) begin
      n++;
      step();
    end
    check("t5_tmo_cycles", n, TIMEOUT);
    check("t5_idone", i_done_o, 1'b1);
    check("t5_ierr", i_err_o, 1'b1);
    $display("xact t5 port=0 timeout after %0d BUS cycles", n);
    i_req_i = 1'b0;
    step();

    // ack and err together resolve as ack
    i_adr_i = 32'h108; i_req_i = 1'b1;
    run_xact("t5b", 1'b0, 0, 1'b1, 1'b1, 32'h55AA55AA, 1'b0);
    i_req_i = 1'b0;
    step();

    // Reset in the middle of a data cycle, then contention after release
    d_we_i = 1'b1; d_adr_i = 32'h500; d_req_i = 1'b1;
    wait_cyc("t6");
    check("t6_tgc_d", tgc_o, 1'b1);
    i_adr_i = 32'h10C; i_req_i = 1'b1;
    rst_i = 1'b1;
    step();
    check("t6_cyc_drop", cyc_o, 1'b0);
    check("t6_stb_drop", stb_o, 1'b0);
    check("t6_no_done", {i_done_o, d_done_o}, 2'b00);
    rst_i = 1'b0;
    step();
    check("t6_regrant_cyc", cyc_o, 1'b1);
    check("t6_regrant_i", tgc_o, 1'b0);
    run_xact("t6_i", 1'b0, 0, 1'b1, 1'b0, 32'h11112222, 1'b0);
    i_req_i = 1'b0;
    run_xact("t6_d", 1'b1, 0, 1'b1, 1'b0, 32'h33334444, 1'b0);
    d_req_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
